// File: rtl/port_irq_pkg.sv
// ---------------------------------------------------------------------------
// port_irq_pkg
//   Shared definitions for the pin-interrupt controller: register map
//   selector, DBCFG field layout and the AHB data-phase record.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package port_irq_pkg;

    // Register selected by HADDR[4:2].
    typedef enum logic [2:0] {
        REG_IEN   = 3'd0,
        REG_ITYP  = 3'd1,
        REG_IPOL  = 3'd2,
        REG_IBOTH = 3'd3,
        REG_IPND  = 3'd4,
        REG_ISTS  = 3'd5,
        REG_DBCFG = 3'd6,
        REG_RSVD  = 3'd7
    } reg_sel_e;

    // DBCFG layout: {[16] DBEN, [15:0] DBDIV}.
    localparam int DBEN_BIT = 16;
    localparam int DBDIV_W  = 16;

    // Address-phase information carried into the data phase.
    typedef struct packed {
        logic     valid;
        logic     write;
        reg_sel_e sel;
    } dphase_t;

endpackage

// File: rtl/port_irq_if.sv
// ---------------------------------------------------------------------------
// port_irq_if
//   AHB-Lite slave bus bundle for port_irq.
//   master modport: drives HSEL/HTRANS/HWRITE/HSIZE/HADDR/HWDATA/HREADY,
//                   receives HREADYOUT/HRDATA/HRESP.
//   slave  modport: the mirror image.
// ---------------------------------------------------------------------------
interface port_irq_if;
    logic        S_HSEL;
    logic [1:0]  S_HTRANS;
    logic        S_HWRITE;
    logic [2:0]  S_HSIZE;
    logic [31:0] S_HADDR;
    logic [31:0] S_HWDATA;
    logic        S_HREADY;
    logic        S_HREADYOUT;
    logic [31:0] S_HRDATA;
    logic        S_HRESP;

    modport master (
        output S_HSEL, S_HTRANS, S_HWRITE, S_HSIZE, S_HADDR, S_HWDATA, S_HREADY,
        input  S_HREADYOUT, S_HRDATA, S_HRESP
    );

    modport slave (
        input  S_HSEL, S_HTRANS, S_HWRITE, S_HSIZE, S_HADDR, S_HWDATA, S_HREADY,
        output S_HREADYOUT, S_HRDATA, S_HRESP
    );
endinterface

// File: rtl/port_irq_filter.sv
// ---------------------------------------------------------------------------
// port_irq_filter
//   One pin: 2-flop synchroniser, optional debounce filter, delayed copy of
//   the filtered level for edge detection.
//   Ports:
//     CLK, RES_N  clock, asynchronous active-low reset
//     pin_in      asynchronous pad level
//     dben        debounce enable (0: filter follows synchroniser each cycle)
//     tick        shared prescaler tick
//     clr         shared pulse clearing the debounce counter (DBEN toggled)
//     filt        filtered level
//     filt_d      filt delayed by one cycle
// ---------------------------------------------------------------------------
module port_irq_filter
    import port_irq_pkg::*;
(
    input  logic CLK,
    input  logic RES_N,
    input  logic pin_in,
    input  logic dben,
    input  logic tick,
    input  logic clr,
    output logic filt,
    output logic filt_d
);

    logic       s1;
    logic       s2;
    logic [1:0] cnt;

    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse s1/s2 into one stage.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pin_in;
            s2 <= s1;
        end
    end

    // The filtered level changes only after three consecutive ticks on
    // which the synchronised level disagrees with it.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            cnt    <= 2'd0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            filt_d <= filt;
            if (!dben) begin
                filt <= s2;
                cnt  <= 2'd0;
            end else if (clr || (s2 == filt)) begin
                cnt <= 2'd0;
            end else if (tick) begin
                if (cnt == 2'd2) begin
                    filt <= s2;
                    cnt  <= 2'd0;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/port_irq.sv
// ---------------------------------------------------------------------------
// port_irq
//   Pin-interrupt controller. Each monitored pin is synchronised, optionally
//   debounced, then level- or edge-detected into a pending latch. Pending
//   bits that are enabled raise a single registered IRQ line.
//   Ports:
//     CLK, RES_N  clock, asynchronous active-low reset
//     bus         AHB-Lite slave (zero wait state, always OKAY)
//     PIN_IN      asynchronous pin levels, WIDTH bits
//     IRQ         registered, level, active-high interrupt request
//   Register map (HADDR[4:2]):
//     0 IEN, 1 ITYP (0 level / 1 edge), 2 IPOL, 3 IBOTH, 4 IPND (W1C),
//     5 ISTS (filtered levels, ro), 6 DBCFG {DBEN, DBDIV}, 7 reads 0.
// ---------------------------------------------------------------------------
module port_irq
    import port_irq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RES_N,
    port_irq_if.slave        bus,
    input  logic [WIDTH-1:0] PIN_IN,
    output logic             IRQ
);

    // ---------------- AHB data-phase tracking ----------------
    dphase_t     dp;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            dp <= '0;
        end else if (bus.S_HREADY) begin
            dp.valid <= bus.S_HSEL & bus.S_HTRANS[1];
            dp.write <= bus.S_HWRITE;
            dp.sel   <= reg_sel_e'(bus.S_HADDR[4:2]);
        end
    end

    assign wdata = bus.S_HWDATA;
    assign wr_en = dp.valid & dp.write & bus.S_HREADY;
    assign rd_en = dp.valid & ~dp.write;

    // HSIZE is ignored and only word-aligned register offsets are decoded.
    logic unused_bus;
    assign unused_bus = ^{bus.S_HSIZE, bus.S_HTRANS[0], bus.S_HADDR[31:5], bus.S_HADDR[1:0]};

    // ---------------- Configuration registers ----------------
    logic [WIDTH-1:0]   ien;
    logic [WIDTH-1:0]   ityp;
    logic [WIDTH-1:0]   ipol;
    logic [WIDTH-1:0]   iboth;
    logic               dben;
    logic [DBDIV_W-1:0] dbdiv;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            ien   <= '0;
            ityp  <= '0;
            ipol  <= '0;
            iboth <= '0;
            dben  <= 1'b0;
            dbdiv <= '0;
        end else if (wr_en) begin
            case (dp.sel)
                REG_IEN:   ien   <= wdata[WIDTH-1:0];
                REG_ITYP:  ityp  <= wdata[WIDTH-1:0];
                REG_IPOL:  ipol  <= wdata[WIDTH-1:0];
                REG_IBOTH: iboth <= wdata[WIDTH-1:0];
                REG_DBCFG: begin
                    dben  <= wdata[DBEN_BIT];
                    dbdiv <= wdata[DBDIV_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Pulse when a DBCFG write flips DBEN: restarts prescaler and counters.
    logic dben_clr;
    assign dben_clr = wr_en & (dp.sel == REG_DBCFG) & (wdata[DBEN_BIT] != dben);

    // ---------------- Debounce prescaler ----------------
    // Counts 0..DBDIV; the >= wrap also recovers if DBDIV is lowered below
    // the running count.
    logic [DBDIV_W-1:0] presc;
    logic               tick;

    assign tick = dben & (presc == dbdiv);

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            presc <= '0;
        end else if (!dben || dben_clr || (presc >= dbdiv)) begin
            presc <= '0;
        end else begin
            presc <= presc + DBDIV_W'(1);
        end
    end

    // ---------------- Per-pin filters ----------------
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        port_irq_filter u_filter (
            .CLK    (CLK),
            .RES_N  (RES_N),
            .pin_in (PIN_IN[i]),
            .dben   (dben),
            .tick   (tick),
            .clr    (dben_clr),
            .filt   (filt[i]),
            .filt_d (filt_d[i])
        );
    end

    // ---------------- Detection and pending ----------------
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] lvl_hit;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] ipnd;

    assign rise     = filt & ~filt_d;
    assign fall     = ~filt & filt_d;
    // IBOTH overrides IPOL for edge-mode pins.
    assign edge_hit = (iboth & (rise | fall)) | (~iboth & ((ipol & rise) | (~ipol & fall)));
    assign lvl_hit  = ~(filt ^ ipol);
    assign set      = ien & ((ityp & edge_hit) | (~ityp & lvl_hit));
    assign w1c      = (wr_en && (dp.sel == REG_IPND)) ? wdata[WIDTH-1:0] : '0;

    // A set in the same cycle as its W1C wins, so no event is lost.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            ipnd <= '0;
            IRQ  <= 1'b0;
        end else begin
            ipnd <= set | (ipnd & ~w1c);
            IRQ  <= |(ipnd & ien);
        end
    end

    // ---------------- Read mux ----------------
    // NOTE: rdata gets its default before the case so no path leaves it
    // unassigned; otherwise the combinational block would infer a latch.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (dp.sel)
                REG_IEN:   rdata = 32'(ien);
                REG_ITYP:  rdata = 32'(ityp);
                REG_IPOL:  rdata = 32'(ipol);
                REG_IBOTH: rdata = 32'(iboth);
                REG_IPND:  rdata = 32'(ipnd);
                REG_ISTS:  rdata = 32'(filt);
                REG_DBCFG: rdata = 32'({dben, dbdiv});
                default:   rdata = '0;
            endcase
        end
    end

    assign bus.S_HRDATA    = rdata;
    assign bus.S_HREADYOUT = 1'b1;
    assign bus.S_HRESP     = 1'b0;

endmodule
